// File: rtl/sd_host_pkg.sv
// Shared SD host definitions: response-receiver FSM encoding, frame/NCR limits and the CRC7 step.
// Used by the CMD response receiver and the CRC7 engine (shared later with the CMD transmit path).
package sd_host_pkg;

    localparam int         SD_RESP_BITS = 48;
    localparam int         SD_NCR_MAX   = 64;
    localparam logic [6:0] SD_CRC7_POLY = 7'h09;

    typedef logic [1:0] sd_rx_state_t;

    localparam sd_rx_state_t ST_IDLE       = 2'd0;
    localparam sd_rx_state_t ST_WAIT_START = 2'd1;
    localparam sd_rx_state_t ST_RECEIVE    = 2'd2;
    localparam sd_rx_state_t ST_DONE       = 2'd3;

    // One serial CRC7 step (x^7 + x^3 + 1), message bits fed MSB first.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
        logic fb;
        fb = crc[6] ^ bit_in;
        return {crc[5:0], 1'b0} ^ (fb ? SD_CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 engine: synchronous clear, one message bit per enabled cycle, running CRC out.
module sd_crc7
    import sd_host_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       enable,
    input  logic       bit_in,
    output logic [6:0] crc
);

    logic [6:0] crc_q;
    logic [6:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clear) begin
            crc_d = 7'h00;
        end else if (enable) begin
            crc_d = crc7_step(crc_q, bit_in);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= 7'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/sd_cmd_response_rx.sv
// SD CMD-line response receiver: waits for the card start bit, captures a 48-bit frame, flags errors.
// Optional CRC7 check of the received frame is built when SD_RESP_CRC_CHECK_EN is defined.
module sd_cmd_response_rx
    import sd_host_pkg::*;
#(
    parameter int RESP_BITS      = SD_RESP_BITS,
    parameter int TIMEOUT_CYCLES = SD_NCR_MAX,
    parameter int CNT_W          = 7
) (
    input  logic                 CLK_SD_card,
    input  logic                 reset,
    input  logic                 start_listening,
    input  logic                 cmd_from_sd,
    output logic                 busy,
    output logic                 done,
    output logic [RESP_BITS-1:0] response,
    output logic [5:0]           resp_index,
    output logic [31:0]          response_status,
    output logic                 timeout_error,
    output logic                 end_bit_error,
    output logic                 crc_error
);

    sd_rx_state_t           state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [RESP_BITS-2:0]   shift_q, shift_d;
    logic [RESP_BITS-1:0]   response_q, response_d;
    logic                   timeout_q, timeout_d;
    logic                   end_bit_err_q, end_bit_err_d;
    logic [RESP_BITS-1:0]   frame;

    // The frame as it stands once the current line sample is appended.
    assign frame = {shift_q, cmd_from_sd};

`ifdef SD_RESP_CRC_CHECK_EN
    logic       crc_clear;
    logic       crc_en;
    logic [6:0] crc_val;
    logic       crc_err_q, crc_err_d;

    sd_crc7 u_crc7 (
        .clk    (CLK_SD_card),
        .rst_n  (reset),
        .clear  (crc_clear),
        .enable (crc_en),
        .bit_in (cmd_from_sd),
        .crc    (crc_val)
    );
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shift_d       = shift_q;
        response_d    = response_q;
        timeout_d     = timeout_q;
        end_bit_err_d = end_bit_err_q;
`ifdef SD_RESP_CRC_CHECK_EN
        crc_clear     = 1'b0;
        crc_en        = 1'b0;
        crc_err_d     = crc_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_listening) begin
                    state_d       = ST_WAIT_START;
                    cnt_d         = '0;
                    timeout_d     = 1'b0;
                    end_bit_err_d = 1'b0;
`ifdef SD_RESP_CRC_CHECK_EN
                    crc_clear     = 1'b1;
                    crc_err_d     = 1'b0;
`endif
                end
            end
            ST_WAIT_START: begin
                if (!cmd_from_sd) begin
                    // A start bit on the final NCR sample still wins over the timeout.
                    state_d = ST_RECEIVE;
                    cnt_d   = CNT_W'(1);
                    shift_d = {shift_q[RESP_BITS-3:0], cmd_from_sd};
`ifdef SD_RESP_CRC_CHECK_EN
                    crc_en  = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d   = ST_DONE;
                        timeout_d = 1'b1;
                    end
                end
            end
            ST_RECEIVE: begin
                shift_d = {shift_q[RESP_BITS-3:0], cmd_from_sd};
                cnt_d   = cnt_q + CNT_W'(1);
`ifdef SD_RESP_CRC_CHECK_EN
                crc_en  = (cnt_q < CNT_W'(RESP_BITS - 8));
`endif
                if (cnt_q == CNT_W'(RESP_BITS - 1)) begin
                    state_d       = ST_DONE;
                    response_d    = frame;
                    end_bit_err_d = frame[RESP_BITS-2] | ~frame[0];
`ifdef SD_RESP_CRC_CHECK_EN
                    crc_err_d     = (frame[7:1] != crc_val);
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_SD_card or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            shift_q       <= '0;
            response_q    <= '0;
            timeout_q     <= 1'b0;
            end_bit_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            response_q    <= response_d;
            timeout_q     <= timeout_d;
            end_bit_err_q <= end_bit_err_d;
        end
    end

`ifdef SD_RESP_CRC_CHECK_EN
    always_ff @(posedge CLK_SD_card or negedge reset) begin
        if (!reset) begin
            crc_err_q <= 1'b0;
        end else begin
            crc_err_q <= crc_err_d;
        end
    end

    assign crc_error = crc_err_q;
`else
    assign crc_error = 1'b0;
`endif

    assign busy            = (state_q == ST_WAIT_START) || (state_q == ST_RECEIVE);
    assign done            = (state_q == ST_DONE);
    assign response        = response_q;
    assign resp_index      = response_q[45:40];
    assign response_status = response_q[39:8];
    assign timeout_error   = timeout_q;
    assign end_bit_error   = end_bit_err_q;

endmodule

// File: tb/tb_sd_cmd_response_rx.sv
// Directed bench for sd_cmd_response_rx: timeout, framing, field extraction, CRC7, re-arm and reset.
// Expected crc_error depends on whether SD_RESP_CRC_CHECK_EN is defined for the build.
module tb_sd_cmd_response_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_listening = 1'b0;
    logic        cmd_line = 1'b1;
    logic        busy;
    logic        done;
    logic [47:0] response;
    logic [5:0]  resp_index;
    logic [31:0] response_status;
    logic        timeout_error;
    logic        end_bit_error;
    logic        crc_error;

    int vectors     = 0;
    int miscompares = 0;

`ifdef SD_RESP_CRC_CHECK_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    sd_cmd_response_rx dut (
        .CLK_SD_card     (clk),
        .reset           (rst_n),
        .start_listening (start_listening),
        .cmd_from_sd     (cmd_line),
        .busy            (busy),
        .done            (done),
        .response        (response),
        .resp_index      (resp_index),
        .response_status (response_status),
        .timeout_error   (timeout_error),
        .end_bit_error   (end_bit_error),
        .crc_error       (crc_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Bench-side CRC7 over 40 message bits, MSB first.
    function automatic logic [6:0] ref_crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = 7'h00;
        for (int i = 39; i >= 0; i--) begin
            fb = c[6] ^ d[i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic exp_crc_err(input logic [47:0] f);
        return CRC_ON && (f[7:1] != ref_crc7(f[47:8]));
    endfunction

    // Arm, keep the line high for 'gap' samples, then drive the frame MSB first.
    task automatic run_frame(input string name, input logic [47:0] f, input int gap,
                             input logic exp_eb);
        logic early;
        @(negedge clk);
        start_listening = 1'b1;
        cmd_line        = 1'b1;
        @(negedge clk);
        start_listening = 1'b0;
        check($sformatf("%s_busy", name), busy, 1'b1);
        early = 1'b0;
        for (int k = 0; k < gap; k++) begin
            cmd_line = 1'b1;
            if (done) early = 1'b1;
            @(negedge clk);
        end
        for (int k = 0; k < 48; k++) begin
            cmd_line = f[47-k];
            if (done) early = 1'b1;
            @(negedge clk);
        end
        cmd_line = 1'b1;
        check($sformatf("%s_no_early_done", name), early, 1'b0);
        check($sformatf("%s_done", name), done, 1'b1);
        check($sformatf("%s_busy_in_done", name), busy, 1'b0);
        check($sformatf("%s_response", name), response, f);
        check($sformatf("%s_index", name), resp_index, f[45:40]);
        check($sformatf("%s_status", name), response_status, f[39:8]);
        check($sformatf("%s_timeout", name), timeout_error, 1'b0);
        check($sformatf("%s_end_bit", name), end_bit_error, exp_eb);
        check($sformatf("%s_crc", name), crc_error, exp_crc_err(f));
        $display("txn %s frame=%h gap=%0d resp=%h idx=%h st=%h to=%b eb=%b crc=%b",
                 name, f, gap, response, resp_index, response_status,
                 timeout_error, end_bit_error, crc_error);
        @(negedge clk);
        check($sformatf("%s_done_pulse", name), done, 1'b0);
    endtask

    initial begin
        int          done_at;
        logic        seen;
        logic [47:0] prev;

        // Reset state
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_response", response, 48'h0);
        check("rst_timeout", timeout_error, 1'b0);
        check("rst_end_bit", end_bit_error, 1'b0);
        check("rst_crc", crc_error, 1'b0);
        rst_n = 1'b1;

        run_frame("t2_clean", 48'h0000_0000_0001, 5, 1'b0);

        // T1 idle line with a re-arm attempt mid-wait and an arm during the done cycle
        prev = response;
        @(negedge clk);
        start_listening = 1'b1;
        @(negedge clk);
        done_at = -1;
        for (int k = 1; k <= 100; k++) begin
            start_listening = (k == 30);
            if (done === 1'b1) begin
                done_at = k;
                break;
            end
            @(negedge clk);
        end
        check("t1_done_latency", 48'(done_at), 48'(65));
        check("t1_timeout", timeout_error, 1'b1);
        check("t1_end_bit", end_bit_error, 1'b0);
        check("t1_crc", crc_error, 1'b0);
        check("t1_busy_in_done", busy, 1'b0);
        check("t1_response_kept", response, prev);
        $display("txn t1_timeout done_at=%0d to=%b resp=%h", done_at, timeout_error, response);
        start_listening = 1'b1;
        @(negedge clk);
        start_listening = 1'b0;
        check("t1_arm_in_done_ignored", busy, 1'b0);
        @(negedge clk);
        check("t1_still_idle", busy, 1'b0);

        run_frame("t3_fields", 48'h3AFA_CACA_DEF3, 0, 1'b0);
        check("t3_index_const", resp_index, 6'h3A);
        check("t3_status_const", response_status, 32'hFACA_CADE);
        run_frame("t4_crc_bad", 48'h0000_0000_0003, 2, 1'b0);
        run_frame("t5_end_zero", 48'h0000_0000_0000, 3, 1'b1);
        run_frame("t5_tx_bit", 48'h4000_0000_0001, 1, 1'b1);
        run_frame("cmd0_crc_ok", 48'h4000_0000_0095, 4, 1'b1);
        run_frame("t6_last_sample", 48'h3AFA_CACA_DEF3, 63, 1'b0);

        // T6 reset in the middle of a frame
        @(negedge clk);
        start_listening = 1'b1;
        @(negedge clk);
        start_listening = 1'b0;
        for (int k = 0; k < 22; k++) begin
            cmd_line = (k < 2) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_done", done, 1'b0);
        check("rstmid_response", response, 48'h0);
        check("rstmid_index", resp_index, 6'h0);
        check("rstmid_status", response_status, 32'h0);
        check("rstmid_flags", {timeout_error, end_bit_error, crc_error}, 3'b000);
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        rst_n    = 1'b0;
        cmd_line = 1'b1;
        check("rstmid_no_done", seen, 1'b0);
        $display("txn reset_mid_frame resp=%h busy=%b", response, busy);
        rst_n = 1'b1;
        run_frame("t6_after_reset", 48'h0000_0000_0001, 5, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
